// File: rtl/fpu_pkg.sv
// Shared FPU definitions: default field widths, normalizer FSM encoding and
// the exponent saturation (all-ones) constant.
package fpu_pkg;

  localparam int MANT_W_DEF = 24;
  localparam int EXP_W_DEF  = 8;

  // Sliced down to the instance's exponent width by the user.
  localparam logic [31:0] EXP_ONES_WIDE = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } norm_state_e;

endpackage

// File: rtl/lzc24.sv
// Leading-zero counter; returns W when the input vector is all zeros.
module lzc24
  import fpu_pkg::*;
#(
  parameter int W  = MANT_W_DEF,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  vec_i,
  output logic [CW-1:0] cnt_o
);

  // Scanning upward lets the highest set bit win.
  always_comb begin
    cnt_o = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (vec_i[i]) cnt_o = CW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/fp_norm_pack.sv
// Post add/sub normalize-and-pack stage with truncation and ovf/unf/zero flags.
// Define FP_NORM_FAST_SHIFT_EN for single-cycle leading-zero normalization.
module fp_norm_pack
  import fpu_pkg::*;
#(
  parameter int MANT_W = MANT_W_DEF,
  parameter int EXP_W  = EXP_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    sign,
  input  logic                    cout,
  input  logic [MANT_W-1:0]       mant,
  input  logic [EXP_W-1:0]        exp,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+MANT_W-1:0] result,
  output logic                    ovf,
  output logic                    unf,
  output logic                    zero
);

  localparam logic [EXP_W-1:0] EXP_ONES = EXP_ONES_WIDE[EXP_W-1:0];
  localparam logic [EXP_W-1:0] EXP_ONE  = EXP_W'(1);

  norm_state_e       state_q, state_d;
  logic              sign_q, sign_d;
  logic [EXP_W-1:0]  exp_q, exp_d;
  logic [MANT_W-1:0] mant_q, mant_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              zero_q, zero_d;
  logic [EXP_W-1:0]  exp_inc;

`ifdef FP_NORM_FAST_SHIFT_EN
  localparam int CW = $clog2(MANT_W + 1);
  logic [CW-1:0] lz_cnt;

  lzc24 #(.W(MANT_W), .CW(CW)) u_lzc (
    .vec_i (mant_q),
    .cnt_o (lz_cnt)
  );
`endif

  assign exp_inc   = exp + EXP_ONE;
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = {sign_q, exp_q, mant_q[MANT_W-2:0]};
  assign ovf       = ovf_q;
  assign unf       = unf_q;
  assign zero      = zero_q;

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    mant_d  = mant_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    zero_d  = zero_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d  = sign;
          exp_d   = exp;
          mant_d  = mant;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          zero_d  = 1'b0;
          state_d = DONE;
          if (cout) begin
            mant_d = {1'b1, mant[MANT_W-1:1]};
            exp_d  = exp_inc;
            // exp already saturated wraps exp_inc to zero, so test both.
            if ((exp_inc == EXP_ONES) || (exp == EXP_ONES)) begin
              exp_d  = EXP_ONES;
              mant_d = '0;
              ovf_d  = 1'b1;
            end
          end else if (mant == '0) begin
            sign_d = 1'b0;
            exp_d  = '0;
            zero_d = 1'b1;
          end else if (!mant[MANT_W-1]) begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (mant_q[MANT_W-1]) begin
          state_d = DONE;
`ifdef FP_NORM_FAST_SHIFT_EN
        end else if (int'(lz_cnt) >= int'(exp_q)) begin
          exp_d   = '0;
          mant_d  = '0;
          unf_d   = 1'b1;
          state_d = DONE;
        end else begin
          mant_d  = mant_q << lz_cnt;
          exp_d   = exp_q - EXP_W'(lz_cnt);
          state_d = DONE;
        end
`else
        end else if (exp_q <= EXP_ONE) begin
          exp_d   = '0;
          mant_d  = '0;
          unf_d   = 1'b1;
          state_d = DONE;
        end else begin
          // Leave as soon as the shift lands a one in the MSB: T+1+k latency.
          mant_d = {mant_q[MANT_W-2:0], 1'b0};
          exp_d  = exp_q - EXP_ONE;
          if (mant_q[MANT_W-2]) state_d = DONE;
        end
`endif
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      mant_q  <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      mant_q  <= mant_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      zero_q  <= zero_d;
    end
  end

endmodule

// File: doc/fp_norm_pack.md
FP_NORM_PACK -- requirements
Module: fp_norm_pack

Interface
REQ-001 SHALL have parameter MANT_W, default 24, mantissa width including the hidden bit.
REQ-002 SHALL have parameter EXP_W, default 8, biased exponent width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1, input beat present.
REQ-006 SHALL have port in_ready, output, 1, block can accept a beat.
REQ-007 SHALL have port sign, input, 1, result sign from the add/sub stage.
REQ-008 SHALL have port cout, input, 1, mantissa carry-out from the add/sub stage.
REQ-009 SHALL have port mant, input, MANT_W, unnormalized mantissa sum or difference.
REQ-010 SHALL have port exp, input, EXP_W, common biased exponent after alignment.
REQ-011 SHALL have port out_valid, output, 1, result present.
REQ-012 SHALL have port out_ready, input, 1, downstream accepts the result.
REQ-013 SHALL have port result, output, 1+EXP_W+MANT_W-1, packed value {sign, exp, mant without hidden bit}.
REQ-014 SHALL have ports ovf, unf and zero, output, 1 each, sticky-per-result flags valid with out_valid.

Function
REQ-015 SHALL use FSM states IDLE, SHIFT and DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-016 SHALL, on the accept cycle (IDLE with in_valid=1), register the inputs and resolve them in the following priority.
- cout=1: mant={1,mant[MSB:1]} and exp+1; if exp+1 equals all-ones, or the input exp is all-ones, result=signed infinity (mantissa 0), ovf=1; go to DONE.
- mant==0: result all-zero with sign 0, zero=1; go to DONE.
- mant[MSB]=1: go to DONE unchanged.
- Otherwise: go to SHIFT.
REQ-017 SHALL, in SHIFT, perform exactly one of the following per cycle.
- mant[MSB]=1: go to DONE.
- Else if exp<=1: result={sign,0...0}, unf=1; go to DONE.
- Else: mant<<=1 and exp-=1.
REQ-018 SHALL truncate; no rounding, no guard bits.
REQ-019 SHALL hold result and flags stable in DONE until out_ready=1, then return to IDLE on that edge; no same-cycle re-accept.
REQ-020 Latency SHALL be: accept at cycle T gives out_valid at T+1 when normalized, zero or carry; T+1+k for k leading zeros (iterative mode).
REQ-021 SHALL treat underflow as occurring iff leading-zero count k >= input exp (exp=0 with nonzero mant and cout=0 gives unf immediately in SHIFT).
REQ-022 SHALL assert at most one of ovf, unf and zero per result.

Reset
REQ-023 SHALL, when rst=1, go to IDLE with out_valid=0, result=0 and ovf=unf=zero=0 on the next edge, overriding any transfer in progress.
REQ-024 SHALL discard, without emitting, a result pending in SHIFT or DONE when reset is applied.

Configuration
REQ-025 SHALL, with FP_NORM_FAST_SHIFT_EN defined, complete SHIFT in one cycle: compute k by leading-zero count; if k>=exp, flush to underflow as in REQ-017; else mant<<=k and exp-=k; latency always T+2 for SHIFT cases.
REQ-026 SHALL, without FP_NORM_FAST_SHIFT_EN, use the iterative one-bit-per-cycle SHIFT; results SHALL be bit-identical in both modes.

Structure
REQ-027 SHALL take state encodings, the all-ones exponent constant and the default field widths from shared package fpu_pkg.
REQ-028 SHALL place the leading-zero counter in sub-module lzc24, instantiated only under FP_NORM_FAST_SHIFT_EN.

Verification
REQ-029 sign=0, cout=0, mant=0x800000, exp=0x7F -> result 0x3F800000 at T+1, no flags.
REQ-030 cout=1, mant=0x000000, exp=0x7F, sign=1 -> result 0xC0000000 at T+1; separately exp=0xFE -> result 0x7F800000 with sign 0, ovf=1.
REQ-031 mant=0x000001, exp=0x80 -> result 0x34800000; out_valid at T+24 iterative, T+2 fast.
REQ-032 mant=0x000010, exp=0x05 -> result 0x00000000 with unf=1; mant=0 -> zero=1.
REQ-033 Hold out_ready=0 for 5 cycles in DONE -> result stable and in_ready=0; in_valid ignored throughout.
REQ-034 Assert rst during SHIFT -> next cycle IDLE, out_valid=0, no result emitted; a beat then presented is processed normally.
